// File: rtl/axi_hs_fifo_slice_pkg.sv
// axi_hs_fifo_slice_pkg: shared defaults, monitor state type, clog2 helper and AFULL_TH legality test
package axi_hs_fifo_slice_pkg;

    localparam int HS_DATA_W = 32;

    typedef enum logic {MON_IDLE, MON_HOLD} mon_state_e;

    function automatic int hs_clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic bit hs_cfg_ok(input int th, input int depth);
        return th >= 1 && th <= depth && depth >= 2 && (1 << hs_clog2(depth)) == depth;
    endfunction

endpackage

// File: rtl/axi_hs_fifo_slice_mon.sv
// hs_proto_mon: sticky valid/ready protocol monitor for any upstream link
//   clk, rst          clock, synchronous active-high reset
//   valid_i, ready_i  handshake of the watched link
//   data_i            payload of the watched link
//   err_o             set once a stalled offer is withdrawn or its payload changes
module hs_proto_mon
    import axi_hs_fifo_slice_pkg::*;
#(
    parameter int W = HS_DATA_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         valid_i,
    input  logic         ready_i,
    input  logic [W-1:0] data_i,
    output logic         err_o
);

    mon_state_e   state_q, state_d;
    logic [W-1:0] data_q;
    logic         err_q, err_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= MON_IDLE;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            data_q  <= data_i;
            err_q   <= err_d;
        end
    end

    // HOLD means the previous cycle offered a beat that was not taken
    always_comb begin
        state_d = (valid_i && !ready_i) ? MON_HOLD : MON_IDLE;
        err_d   = err_q | (state_q == MON_HOLD && (!valid_i || data_i != data_q));
    end

    assign err_o = err_q;

endmodule

// File: rtl/axi_hs_fifo_slice.sv
// axi_hs_fifo_slice: valid/ready buffer decoupling s_ready from m_ready, with beat counter and protocol monitor
//   clk, rst                   clock, synchronous active-high reset
//   s_data, s_valid, s_ready   upstream link (this block is the slave)
//   m_data, m_valid, m_ready   downstream link (this block is the master)
//   level, almost_full         occupancy and threshold flag
//   data_success, xfer_cnt     pulse after each downstream beat, wrapping beat count
//   protocol_err               sticky upstream handshake violation
module axi_hs_fifo_slice
    import axi_hs_fifo_slice_pkg::*;
#(
    parameter int DATA_W   = HS_DATA_W,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3,
    parameter int CNT_W    = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [DATA_W-1:0]        s_data,
    input  logic                     s_valid,
    output logic                     s_ready,
    output logic [DATA_W-1:0]        m_data,
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [hs_clog2(DEPTH):0] level,
    output logic                     almost_full,
    output logic                     data_success,
    output logic [CNT_W-1:0]         xfer_cnt,
    output logic                     protocol_err
);

    localparam int AW = hs_clog2(DEPTH);
    localparam int LW = AW + 1;

    if (!hs_cfg_ok(AFULL_TH, DEPTH)) begin : g_bad_cfg
        $error("axi_hs_fifo_slice: DEPTH must be a power of two >= 2 and AFULL_TH in 1..DEPTH");
    end

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]     level_q, level_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              succ_q, push, pop;

    // s_ready only looks at the held level, so m_ready never reaches it combinationally
    assign s_ready      = !rst && level_q != LW'(DEPTH);
    assign m_valid      = level_q != '0;
    assign m_data       = mem_q[rd_ptr_q];
    assign level        = level_q;
    assign almost_full  = level_q >= LW'(AFULL_TH);
    assign data_success = succ_q;
    assign xfer_cnt     = cnt_q;

    always_comb begin
        push     = s_valid && s_ready;
        pop      = m_valid && m_ready;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);
        cnt_d    = cnt_q + CNT_W'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            cnt_q    <= '0;
            succ_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            succ_q   <= pop;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= s_data;
    end

    hs_proto_mon #(.W(DATA_W)) u_mon (
        .clk    (clk),
        .rst    (rst),
        .valid_i(s_valid),
        .ready_i(s_ready),
        .data_i (s_data),
        .err_o  (protocol_err)
    );

endmodule
